// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - strobe and status bundle between stack_ctrl and its datapath
// master side is the controller; slave side is the datapath.
interface stack_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11,
  parameter int PTR_W     = 6
);
  logic [OPCODE_W-1:0]  instruction;
  logic [OPERAND_W-1:0] operand;
  logic                 mem_ack;
  logic                 memd_ack;
  logic [DATA_W-1:0]    data_out_memd;
  logic [DATA_W-1:0]    temp1_data;
  logic [DATA_W-1:0]    alu_result;
  logic                 zf;
  logic                 gf;
  logic                 lf;

  logic rd_mem, wr_ir, rd_ir, rd_temp1, wr_temp1, wr_temp2;
  logic rd_memd, wr_memd, alu_en;
  logic wr_ip, rd_ip, inc_ip, ip_src;
  logic push_stack, pop_stack, push_rtn, pop_rtn;
  logic rst_all;
  logic [DATA_W-1:0] stack_data;
  logic [PTR_W-1:0]  tos_ptr;
  logic [PTR_W-1:0]  rtn_ptr;
  logic              halted;
  logic              fault;
  logic [2:0]        fault_code;

  modport master (
    input  instruction, operand, mem_ack, memd_ack, data_out_memd, temp1_data,
           alu_result, zf, gf, lf,
    output rd_mem, wr_ir, rd_ir, rd_temp1, wr_temp1, wr_temp2, rd_memd, wr_memd,
           alu_en, wr_ip, rd_ip, inc_ip, ip_src, push_stack, pop_stack, push_rtn,
           pop_rtn, rst_all, stack_data, tos_ptr, rtn_ptr, halted, fault, fault_code
  );

  modport slave (
    output instruction, operand, mem_ack, memd_ack, data_out_memd, temp1_data,
           alu_result, zf, gf, lf,
    input  rd_mem, wr_ir, rd_ir, rd_temp1, wr_temp1, wr_temp2, rd_memd, wr_memd,
           alu_en, wr_ip, rd_ip, inc_ip, ip_src, push_stack, pop_stack, push_rtn,
           pop_rtn, rst_all, stack_data, tos_ptr, rtn_ptr, halted, fault, fault_code
  );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - fetch/decode/execute control FSM for the stack-machine core
// Strobes are decoded from the state register; stack pointers and push data are registered here.
module stack_ctrl #(
  parameter int DATA_W      = 16,
  parameter int OPCODE_W    = 5,
  parameter int OPERAND_W   = 11,
  parameter int STACK_DEPTH = 32,
  parameter int RTN_DEPTH   = 16,
  parameter int PTR_W       = 6
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.master bus
);

  localparam logic [OPCODE_W-1:0] OP_PUSH   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_PUSH_I = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_PUSH_T = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_POP    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_CMP    = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_NOT    = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_GOTO   = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_IF_EQ  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_IF_GT  = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_IF_LT  = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_IF_GE  = OPCODE_W'(18);
  localparam logic [OPCODE_W-1:0] OP_IF_LE  = OPCODE_W'(19);
  localparam logic [OPCODE_W-1:0] OP_CALL   = OPCODE_W'(20);
  localparam logic [OPCODE_W-1:0] OP_RET    = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(31);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_POP_A, S_POP_B, S_EXEC,
    S_PUSH, S_JUMP, S_CALL, S_RET, S_RET_LD, S_NEXT, S_HALT, S_FAULT
  } state_t;

  state_t state, next_state;

  logic [OPCODE_W-1:0]  op_q;
  logic [DATA_W-1:0]    sd_q, sd_nxt;
  logic [PTR_W-1:0]     tos_q, rtn_q;
  logic [2:0]           code_q, code_nxt;
  logic                 ld_op, ld_sd, ld_code;
  logic [OPERAND_W-1:0] operand_w;
  logic                 is_bin, is_push, is_unary;

  logic rd_mem, wr_ir, rd_ir, rd_temp1, wr_temp1, wr_temp2;
  logic rd_memd, wr_memd, alu_en, wr_ip, rd_ip, inc_ip, ip_src;
  logic push_stack, pop_stack, push_rtn, pop_rtn, rst_all;

  assign operand_w = bus.operand;
  assign is_bin    = (bus.instruction >= OP_ADD) && (bus.instruction <= OP_CMP);
  assign is_push   = (bus.instruction <= OP_PUSH_T);
  assign is_unary  = (bus.instruction == OP_POP) || (bus.instruction == OP_NOT);

  always_comb begin
    next_state = state;
    ld_op      = 1'b0;
    ld_sd      = 1'b0;
    sd_nxt     = '0;
    ld_code    = 1'b0;
    code_nxt   = 3'd0;
    rd_mem     = 1'b0;
    wr_ir      = 1'b0;
    rd_ir      = 1'b0;
    rd_temp1   = 1'b0;
    wr_temp1   = 1'b0;
    wr_temp2   = 1'b0;
    rd_memd    = 1'b0;
    wr_memd    = 1'b0;
    alu_en     = 1'b0;
    wr_ip      = 1'b0;
    rd_ip      = 1'b0;
    inc_ip     = 1'b0;
    ip_src     = 1'b0;
    push_stack = 1'b0;
    pop_stack  = 1'b0;
    push_rtn   = 1'b0;
    pop_rtn    = 1'b0;
    rst_all    = 1'b0;

    case (state)
      S_RESET: begin
        rst_all    = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        rd_mem = 1'b1;
        if (bus.mem_ack) begin
          wr_ir      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        rd_ir = 1'b1;
        ld_op = 1'b1;
        // All depth checks come first so a faulting instruction never touches a stack.
        if (bus.instruction == OP_HALT) begin
          next_state = S_HALT;
        end else if (bus.instruction > OP_RET) begin
          ld_code = 1'b1; code_nxt = 3'd5; next_state = S_FAULT;
        end else if ((is_unary && tos_q == '0) || (is_bin && tos_q < PTR_W'(2))) begin
          ld_code = 1'b1; code_nxt = 3'd1; next_state = S_FAULT;
        end else if (is_push && tos_q >= PTR_W'(STACK_DEPTH)) begin
          ld_code = 1'b1; code_nxt = 3'd2; next_state = S_FAULT;
        end else if (bus.instruction == OP_CALL && rtn_q >= PTR_W'(RTN_DEPTH)) begin
          ld_code = 1'b1; code_nxt = 3'd3; next_state = S_FAULT;
        end else if (bus.instruction == OP_RET && rtn_q == '0) begin
          ld_code = 1'b1; code_nxt = 3'd4; next_state = S_FAULT;
        end else begin
          case (bus.instruction)
            OP_PUSH:   next_state = S_MEM_RD;
            OP_PUSH_I: begin
              ld_sd = 1'b1; sd_nxt = DATA_W'(operand_w); next_state = S_PUSH;
            end
            OP_PUSH_T: begin
              rd_temp1 = 1'b1; ld_sd = 1'b1; sd_nxt = bus.temp1_data; next_state = S_PUSH;
            end
            OP_GOTO:   next_state = S_JUMP;
            OP_IF_EQ:  next_state = bus.zf ? S_JUMP : S_NEXT;
            OP_IF_GT:  next_state = bus.gf ? S_JUMP : S_NEXT;
            OP_IF_LT:  next_state = bus.lf ? S_JUMP : S_NEXT;
            OP_IF_GE:  next_state = (bus.gf | bus.zf) ? S_JUMP : S_NEXT;
            OP_IF_LE:  next_state = (bus.lf | bus.zf) ? S_JUMP : S_NEXT;
            OP_CALL:   next_state = S_CALL;
            OP_RET:    next_state = S_RET;
            default:   next_state = S_POP_A;
          endcase
        end
      end
      S_MEM_RD: begin
        rd_memd = 1'b1;
        if (bus.memd_ack) begin
          ld_sd = 1'b1; sd_nxt = bus.data_out_memd; next_state = S_PUSH;
        end
      end
      S_MEM_WR: begin
        wr_memd  = 1'b1;
        rd_temp1 = 1'b1;
        if (bus.memd_ack) next_state = S_NEXT;
      end
      S_POP_A: begin
        pop_stack = 1'b1;
        wr_temp1  = 1'b1;
        if (op_q == OP_POP)      next_state = S_MEM_WR;
        else if (op_q == OP_NOT) next_state = S_EXEC;
        else                     next_state = S_POP_B;
      end
      S_POP_B: begin
        pop_stack  = 1'b1;
        wr_temp2   = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        alu_en     = 1'b1;
        ld_sd      = 1'b1;
        sd_nxt     = bus.alu_result;
        next_state = (op_q == OP_CMP) ? S_NEXT : S_PUSH;
      end
      S_PUSH: begin
        push_stack = 1'b1;
        next_state = S_NEXT;
      end
      S_JUMP: begin
        wr_ip      = 1'b1;
        next_state = S_FETCH;
      end
      S_CALL: begin
        push_rtn   = 1'b1;
        rd_ip      = 1'b1;
        next_state = S_JUMP;
      end
      S_RET: begin
        pop_rtn    = 1'b1;
        next_state = S_RET_LD;
      end
      S_RET_LD: begin
        wr_ip      = 1'b1;
        ip_src     = 1'b1;
        next_state = S_NEXT;
      end
      S_NEXT: begin
        inc_ip     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_RESET;
      op_q   <= '0;
      sd_q   <= '0;
      tos_q  <= '0;
      rtn_q  <= '0;
      code_q <= 3'd0;
    end else begin
      state <= next_state;
      if (ld_op)   op_q   <= bus.instruction;
      if (ld_sd)   sd_q   <= sd_nxt;
      if (ld_code) code_q <= code_nxt;
      if (push_stack)     tos_q <= tos_q + PTR_W'(1);
      else if (pop_stack) tos_q <= tos_q - PTR_W'(1);
      if (push_rtn)       rtn_q <= rtn_q + PTR_W'(1);
      else if (pop_rtn)   rtn_q <= rtn_q - PTR_W'(1);
    end
  end

  assign bus.rd_mem     = rd_mem;
  assign bus.wr_ir      = wr_ir;
  assign bus.rd_ir      = rd_ir;
  assign bus.rd_temp1   = rd_temp1;
  assign bus.wr_temp1   = wr_temp1;
  assign bus.wr_temp2   = wr_temp2;
  assign bus.rd_memd    = rd_memd;
  assign bus.wr_memd    = wr_memd;
  assign bus.alu_en     = alu_en;
  assign bus.wr_ip      = wr_ip;
  assign bus.rd_ip      = rd_ip;
  assign bus.inc_ip     = inc_ip;
  assign bus.ip_src     = ip_src;
  assign bus.push_stack = push_stack;
  assign bus.pop_stack  = pop_stack;
  assign bus.push_rtn   = push_rtn;
  assign bus.pop_rtn    = pop_rtn;
  assign bus.rst_all    = rst_all;
  assign bus.stack_data = sd_q;
  assign bus.tos_ptr    = tos_q;
  assign bus.rtn_ptr    = rtn_q;
  assign bus.halted     = (state == S_HALT);
  assign bus.fault      = (state == S_FAULT);
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed and randomized checks of stack_ctrl against a queue-based model
// The model tracks stack contents with queues and derives strobe counts and latency per opcode.
module tb_stack_ctrl;
  localparam int DATA_W = 16, OPCODE_W = 5, OPERAND_W = 11;
  localparam int STACK_DEPTH = 32, RTN_DEPTH = 16, PTR_W = 6;

  localparam logic [4:0] PUSH = 0, PUSH_I = 1, PUSH_T = 2, POP = 3, ADD = 4, CMP = 12;
  localparam logic [4:0] NOT_OP = 13, GOTO = 14, IF_EQ = 15, IF_GT = 16, IF_LT = 17;
  localparam logic [4:0] IF_GE = 18, IF_LE = 19, CALL = 20, RET = 21, HALT = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .PTR_W(PTR_W)) bus ();

  stack_ctrl #(
    .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W),
    .STACK_DEPTH(STACK_DEPTH), .RTN_DEPTH(RTN_DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int stk[$];
  int rq[$];

  int cyc, n_push, n_pop, n_alu, n_wrip, n_inc, n_rdmd, n_wrmd, n_prtn, n_poprtn, n_wrir, n_dec;
  int tos_min;
  logic ipsrc;
  logic [15:0] sd_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    bus.memd_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stk.delete();
    rq.delete();
  endtask

  // Entered at a falling edge in FETCH; returns at the falling edge of the next FETCH, HALT or FAULT.
  task automatic run_instr(input logic [4:0] op, input logic [10:0] opnd, input int mwait, input int dwait);
    int mseen = 0;
    int dseen = 0;
    bit done = 0;
    bus.instruction = op;
    bus.operand = opnd;
    cyc = 0; n_push = 0; n_pop = 0; n_alu = 0; n_wrip = 0; n_inc = 0; n_rdmd = 0;
    n_wrmd = 0; n_prtn = 0; n_poprtn = 0; n_wrir = 0; n_dec = 0;
    tos_min = int'(bus.tos_ptr);
    ipsrc = 1'b0;
    sd_push = '0;
    while (!done) begin
      if (bus.push_stack) begin n_push++; sd_push = bus.stack_data; end
      if (bus.pop_stack) n_pop++;
      if (bus.alu_en) n_alu++;
      if (bus.wr_ip) begin n_wrip++; ipsrc = bus.ip_src; end
      if (bus.inc_ip) n_inc++;
      if (bus.rd_memd) n_rdmd++;
      if (bus.wr_memd) n_wrmd++;
      if (bus.push_rtn) n_prtn++;
      if (bus.pop_rtn) n_poprtn++;
      if (bus.rd_ir) n_dec++;
      bus.mem_ack = bus.rd_mem && (mseen >= mwait);
      if (bus.rd_mem) mseen++;
      bus.memd_ack = (bus.rd_memd || bus.wr_memd) && (dseen >= dwait);
      if (bus.rd_memd || bus.wr_memd) dseen++;
      #1;
      if (bus.wr_ir) n_wrir++;
      @(negedge clk);
      cyc++;
      if (int'(bus.tos_ptr) < tos_min) tos_min = int'(bus.tos_ptr);
      if (bus.halted || bus.fault) done = 1;
      else if (bus.rd_mem && n_dec > 0) done = 1;
      else if (cyc >= 64) begin
        done = 1;
        total++;
        bad++;
        $error("FAIL timeout op=%0d cycles=%0d limit=64", op, cyc);
      end
    end
    bus.mem_ack = 1'b0;
    bus.memd_ack = 1'b0;
  endtask

  task automatic do_instr(input logic [4:0] op, input logic [10:0] opnd, input int mwait,
                          input int dwait, input logic z, input logic g, input logic l);
    int sz = stk.size();
    int rs = rq.size();
    int ecode = 0;
    int e_push = 0, e_pop = 0, e_alu = 0, e_wrip = 0, e_inc = 1, e_src = 0;
    int e_prtn = 0, e_poprtn = 0, e_rd = 0, e_wr = 0, e_lat = 0;
    logic [15:0] e_val = '0;
    logic cond;
    bus.zf = z; bus.gf = g; bus.lf = l;

    if (op == HALT) ecode = 0;
    else if (op > RET) ecode = 5;
    else if ((op == POP || op == NOT_OP) && sz < 1) ecode = 1;
    else if (op >= ADD && op <= CMP && sz < 2) ecode = 1;
    else if (op <= PUSH_T && sz >= STACK_DEPTH) ecode = 2;
    else if (op == CALL && rs >= RTN_DEPTH) ecode = 3;
    else if (op == RET && rs == 0) ecode = 4;

    run_instr(op, opnd, mwait, dwait);

    if (op == HALT) begin
      chk("halted", bus.halted, 1);
      chk("halt_no_fault", bus.fault, 0);
      return;
    end
    if (ecode != 0) begin
      chk($sformatf("fault_op%0d", op), bus.fault, 1);
      chk($sformatf("fault_code_op%0d", op), bus.fault_code, ecode);
      chk("fault_no_pop", n_pop, 0);
      chk("fault_no_push", n_push + n_prtn + n_poprtn, 0);
      chk("fault_tos_kept", bus.tos_ptr, sz);
      do_reset();
      return;
    end

    case (op)
      IF_EQ: cond = z;
      IF_GT: cond = g;
      IF_LT: cond = l;
      IF_GE: cond = g | z;
      default: cond = l | z;
    endcase
    case (op)
      PUSH:   begin e_push = 1; e_val = bus.data_out_memd; e_lat = 5 + dwait; e_rd = dwait + 1; end
      PUSH_I: begin e_push = 1; e_val = {5'b0, opnd}; e_lat = 4; end
      PUSH_T: begin e_push = 1; e_val = bus.temp1_data; e_lat = 4; end
      POP:    begin e_pop = 1; e_lat = 5 + dwait; e_wr = dwait + 1; end
      CMP:    begin e_pop = 2; e_alu = 1; e_lat = 6; end
      NOT_OP: begin e_pop = 1; e_alu = 1; e_push = 1; e_val = bus.alu_result; e_lat = 6; end
      GOTO:   begin e_wrip = 1; e_inc = 0; e_lat = 3; end
      IF_EQ, IF_GT, IF_LT, IF_GE, IF_LE: begin
        e_wrip = cond ? 1 : 0; e_inc = cond ? 0 : 1; e_lat = 3;
      end
      CALL:   begin e_prtn = 1; e_wrip = 1; e_inc = 0; e_lat = 4; end
      RET:    begin e_poprtn = 1; e_wrip = 1; e_src = 1; e_lat = 5; end
      default: begin e_pop = 2; e_alu = 1; e_push = 1; e_val = bus.alu_result; e_lat = 7; end
    endcase
    e_lat += mwait;

    for (int i = 0; i < e_pop; i++) void'(stk.pop_back());
    if (e_push != 0) stk.push_back(int'(e_val));
    if (e_prtn != 0) rq.push_back(int'(opnd));
    if (e_poprtn != 0) void'(rq.pop_back());

    chk($sformatf("latency_op%0d", op), cyc, e_lat);
    chk($sformatf("push_cnt_op%0d", op), n_push, e_push);
    chk($sformatf("pop_cnt_op%0d", op), n_pop, e_pop);
    chk($sformatf("alu_cnt_op%0d", op), n_alu, e_alu);
    chk($sformatf("wr_ip_op%0d", op), n_wrip, e_wrip);
    chk($sformatf("inc_ip_op%0d", op), n_inc, e_inc);
    if (e_wrip != 0) chk($sformatf("ip_src_op%0d", op), ipsrc, e_src);
    if (e_push != 0) chk($sformatf("stack_data_op%0d", op), sd_push, e_val);
    chk($sformatf("rd_memd_op%0d", op), n_rdmd, e_rd);
    chk($sformatf("wr_memd_op%0d", op), n_wrmd, e_wr);
    chk($sformatf("push_rtn_op%0d", op), n_prtn, e_prtn);
    chk($sformatf("pop_rtn_op%0d", op), n_poprtn, e_poprtn);
    chk($sformatf("wr_ir_op%0d", op), n_wrir, 1);
    chk($sformatf("tos_ptr_op%0d", op), bus.tos_ptr, stk.size());
    chk($sformatf("tos_min_op%0d", op), tos_min, sz - e_pop);
    chk($sformatf("rtn_ptr_op%0d", op), bus.rtn_ptr, rq.size());
    chk("no_fault", bus.fault, 0);
  endtask

  initial begin
    int guard;
    logic [4:0] rop;
    int r, f;

    bus.instruction = '0; bus.operand = '0; bus.mem_ack = 1'b0; bus.memd_ack = 1'b0;
    bus.data_out_memd = '0; bus.temp1_data = '0; bus.alu_result = '0;
    bus.zf = 1'b0; bus.gf = 1'b0; bus.lf = 1'b0;

    #3;
    chk("rst_rst_all", bus.rst_all, 1);
    chk("rst_rd_mem", bus.rd_mem, 0);
    chk("rst_status", {bus.halted, bus.fault, bus.fault_code}, 0);
    chk("rst_ptrs", {bus.tos_ptr, bus.rtn_ptr, bus.stack_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_rst_all", bus.rst_all, 1);
    @(negedge clk);
    chk("release_fetch", {bus.rst_all, bus.rd_mem}, 2'b01);

    bus.alu_result = 16'd12;
    do_instr(PUSH_I, 11'd5, 0, 0, 0, 0, 0);
    do_instr(PUSH_I, 11'd7, 0, 0, 0, 0, 0);
    do_instr(ADD, 11'd0, 0, 0, 0, 0, 0);

    bus.data_out_memd = 16'hBEEF;
    do_instr(PUSH, 11'd3, 0, 3, 0, 0, 0);
    do_instr(CMP, 11'd0, 0, 0, 0, 0, 0);
    do_instr(IF_EQ, 11'h40, 0, 0, 1, 0, 0);
    do_instr(IF_EQ, 11'h40, 0, 0, 0, 1, 0);
    do_instr(CALL, 11'h100, 1, 0, 0, 0, 0);
    do_instr(RET, 11'd0, 0, 0, 0, 0, 0);

    do_instr(PUSH_I, 11'd1, 0, 0, 0, 0, 0);
    do_instr(ADD, 11'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < STACK_DEPTH; i++) do_instr(PUSH_I, 11'(i), 0, 0, 0, 0, 0);
    do_instr(PUSH_I, 11'd9, 0, 0, 0, 0, 0);
    do_instr(5'd25, 11'd0, 0, 0, 0, 0, 0);
    do_instr(RET, 11'd0, 0, 0, 0, 0, 0);

    // Asynchronous reset while an ADD sits in EXEC.
    for (int i = 0; i < 3; i++) do_instr(PUSH_I, 11'd7, 0, 0, 0, 0, 0);
    bus.instruction = ADD;
    bus.mem_ack = 1'b1;
    guard = 0;
    while (!bus.alu_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $error("FAIL wait_exec cycles=%0d limit=20", guard);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_all", bus.rst_all, 1);
    chk("async_strobes", {bus.alu_en, bus.push_stack, bus.pop_stack, bus.rd_mem, bus.inc_ip}, 0);
    chk("async_stack_data", bus.stack_data, 0);
    chk("async_tos", bus.tos_ptr, 0);
    chk("async_status", {bus.halted, bus.fault, bus.fault_code, bus.rtn_ptr}, 0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_release_rst_all", {bus.rst_all, bus.rd_mem}, 2'b10);
    @(negedge clk);
    chk("async_release_fetch", {bus.rst_all, bus.rd_mem}, 2'b01);
    stk.delete();
    rq.delete();

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) rop = 5'(22 + $urandom_range(0, 8));
      else if (r < 38) rop = 5'($urandom_range(0, 2));
      else rop = 5'($urandom_range(0, 21));
      f = int'($urandom_range(0, 2));
      bus.data_out_memd = 16'($urandom);
      bus.temp1_data = 16'($urandom);
      bus.alu_result = 16'($urandom);
      do_instr(rop, 11'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               f == 0, f == 1, f == 2);
    end

    do_instr(HALT, 11'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_held", {bus.halted, bus.fault, bus.rd_mem}, 3'b100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
